gray_checker: RTL and testbench
===============================

# gray_checker

Downstream monitor for the 3-bit Gray-code sequence generator. Each enabled cycle it samples the incoming Gray code and converts it to binary. It checks that every step is a legal single advance (+1 mod 8) and counts full sequence wraps and illegal transitions. It sits between the Gray counter and the board display/LED logic, giving a registered binary value plus health status.

## Interface
- `WRAP_W`, default 8: width of the wrap counter.
- `ERR_W`, default 4: width of the saturating error counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `code`  in  3  Gray code from the upstream counter.
- `en`  in  1  sample qualifier. When low, the cycle is ignored.
- `clr`  in  1  synchronous clear of `err_cnt`, `wrap_cnt` and `err_sticky`.
- `bin`  out  3  registered binary value of the last sampled code.
- `valid`  out  1  high once at least one sample has been taken since reset.
- `step_ok`  out  1  one-cycle pulse for a legal +1 step.
- `err`  out  1  one-cycle pulse for an illegal transition.
- `err_sticky`  out  1  set by any `err`; cleared only by `reset` or `clr`.
- `err_cnt`  out  ERR_W  number of illegal transitions, saturating at 2^ERR_W−1.
- `wrap_cnt`  out  WRAP_W  number of legal 7→0 steps, modulo 2^WRAP_W.

## Operation
- **Gray-to-binary conversion:** b2=g2, b1=g2^g1, b0=b1^g0. Combinational on `code`, registered into `bin` on a sampled cycle.
- **Sampled cycle:** `en`=1 at a rising edge. Unsampled cycles hold all state and drive pulses low.
- **States:** INIT, TRACK, RESYNC.
  - INIT, sampled: load `bin`, set `valid`, go to TRACK. No pulse.
  - TRACK, sampled: let new = conv(`code`) and prev = `bin`.
    - new == prev+1 mod 8: `step_ok`=1, stay in TRACK.
    - Anything else, including new == prev: `err`=1, go to RESYNC with the good-step count at 0.
    - `bin` is loaded with new in both cases.
  - RESYNC, sampled:
    - Legal step: `step_ok`=1 and the good-step count increments. On the 2nd consecutive legal step, go to TRACK.
    - Illegal step: `err`=1, good-step count returns to 0, stay in RESYNC.
- **Wrap:** `wrap_cnt` increments on any `step_ok` where prev=7 and new=0. It wraps from 2^WRAP_W−1 to 0.
- **Error count:** `err_cnt` increments on each `err` and saturates (no wrap).
- **`clr` priority:** `clr` wins over a same-cycle increment or sticky set. The counters go to 0 and `err_sticky` to 0. The `err`/`step_ok` pulses are still driven. FSM, `bin` and `valid` are unaffected.

## Timing
- **Latency:** 1 cycle. `code` sampled at edge k is reflected in `bin`, `step_ok`, `err`, the counters and the state after edge k.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Reset values** (asynchronous, when `reset`=0): state=INIT, `bin`=0, `valid`=0, `step_ok`=0, `err`=0, `err_sticky`=0, `err_cnt`=0, `wrap_cnt`=0.
- **Reset mid-operation:** all outputs go to reset values immediately. After `reset` is released, the first sampled cycle is treated as INIT, so no error is flagged regardless of `code`.
- **`en` low for N cycles:** no effect. The next sampled code is compared against the last sampled `bin`.
- The upstream counter advances every clock, so with `en` held at 1 every cycle after the first is a `step_ok` cycle.

## Test plan
- **Reset:** hold `reset`=0 with random `code`/`en` → all outputs 0 and state INIT. Release, then sample `code`=011 → `bin`=2, `valid`=1, no `step_ok`/`err`.
- **Clean sequence:** `en`=1, feed 000,001,011,010,110,111,101,100,000 (9 samples) → `bin` 0..7,0. `step_ok` on samples 2–9. `wrap_cnt`=1 after sample 9. `err_cnt`=0.
- **Illegal step:** feed 000,001,011,110 (bin 0,1,2,4) → `err` pulse on the 4th sample, `err_cnt`=1, `err_sticky`=1, state RESYNC.
  - Then feed 111,101 → `step_ok` on both, state TRACK after 101.
- **Stall and saturation:** in TRACK with `en` held at 1, repeat the same code 20 times → 20 `err` pulses, `err_cnt`=15 with ERR_W=4, `err_sticky`=1.
  - Also apply `en`=0 gaps of 5 cycles between legal codes → no pulses during the gaps, `step_ok` on resume.
- **Clear collision:** assert `clr` in the same cycle as an illegal sample → `err`=1 that cycle, `err_cnt`=0, `err_sticky`=0, `bin` updated. Assert `clr` on a 7→0 step → `wrap_cnt`=0.
- **Reset mid-stream:** pull `reset` low after bin=5 → immediate reset values. Release and sample 010 → `bin`=3, `valid`=1, `err`=0.

Source files
------------

// File: rtl/gray_checker.sv
// Monitor for a 3-bit Gray-code counter.
// Tracks legal +1 steps, counts wraps and saturating errors, and resyncs after faults.
module gray_checker #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        code,
  input  logic              en,
  input  logic              clr,
  output logic [2:0]        bin,
  output logic              valid,
  output logic              step_ok,
  output logic              err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {INIT, TRACK, RESYNC} state_t;

  state_t              state_reg, state_next;
  logic                good_reg, good_next;
  logic [2:0]          bin_reg, bin_next;
  logic                valid_reg, valid_next;
  logic                step_ok_reg, step_ok_next;
  logic                err_reg, err_next;
  logic                sticky_reg, sticky_next;
  logic [ERR_W-1:0]    err_cnt_reg, err_cnt_next;
  logic [WRAP_W-1:0]   wrap_cnt_reg, wrap_cnt_next;

  logic [2:0]          conv_bin;
  logic                legal;

  assign conv_bin[2] = code[2];
  assign conv_bin[1] = code[2] ^ code[1];
  assign conv_bin[0] = code[2] ^ code[1] ^ code[0];
  assign legal       = (conv_bin == bin_reg + 3'd1);

  always_comb begin
    state_next    = state_reg;
    good_next     = good_reg;
    bin_next      = bin_reg;
    valid_next    = valid_reg;
    step_ok_next  = 1'b0;
    err_next      = 1'b0;
    sticky_next   = sticky_reg;
    err_cnt_next  = err_cnt_reg;
    wrap_cnt_next = wrap_cnt_reg;

    if (en) begin
      bin_next = conv_bin;
      case (state_reg)
        INIT: begin
          valid_next = 1'b1;
          state_next = TRACK;
        end
        TRACK: begin
          if (legal) begin
            step_ok_next = 1'b1;
          end else begin
            err_next   = 1'b1;
            good_next  = 1'b0;
            state_next = RESYNC;
          end
        end
        RESYNC: begin
          if (legal) begin
            step_ok_next = 1'b1;
            // good_reg set means this is the second consecutive legal step
            if (good_reg) begin
              good_next  = 1'b0;
              state_next = TRACK;
            end else begin
              good_next = 1'b1;
            end
          end else begin
            err_next  = 1'b1;
            good_next = 1'b0;
          end
        end
        default: state_next = INIT;
      endcase
    end

    if (step_ok_next && bin_reg == 3'd7)
      wrap_cnt_next = wrap_cnt_reg + WRAP_W'(1);
    if (err_next) begin
      sticky_next = 1'b1;
      if (err_cnt_reg != {ERR_W{1'b1}})
        err_cnt_next = err_cnt_reg + ERR_W'(1);
    end

    // Clear overrides same-cycle increments but leaves pulses and tracking intact
    if (clr) begin
      sticky_next   = 1'b0;
      err_cnt_next  = '0;
      wrap_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= INIT;
      good_reg     <= 1'b0;
      bin_reg      <= 3'd0;
      valid_reg    <= 1'b0;
      step_ok_reg  <= 1'b0;
      err_reg      <= 1'b0;
      sticky_reg   <= 1'b0;
      err_cnt_reg  <= '0;
      wrap_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      good_reg     <= good_next;
      bin_reg      <= bin_next;
      valid_reg    <= valid_next;
      step_ok_reg  <= step_ok_next;
      err_reg      <= err_next;
      sticky_reg   <= sticky_next;
      err_cnt_reg  <= err_cnt_next;
      wrap_cnt_reg <= wrap_cnt_next;
    end
  end

  assign bin        = bin_reg;
  assign valid      = valid_reg;
  assign step_ok    = step_ok_reg;
  assign err        = err_reg;
  assign err_sticky = sticky_reg;
  assign err_cnt    = err_cnt_reg;
  assign wrap_cnt   = wrap_cnt_reg;

endmodule

// File: tb/tb_gray_checker.sv
// Randomized and directed bench for gray_checker against a sequence-level model.
module tb_gray_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] code = 3'd0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] bin;
  logic       valid, step_ok, err, err_sticky;
  logic [3:0] err_cnt;
  logic [7:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  // model: m_need = legal steps still required before the monitor is back in step
  bit m_valid;
  int m_bin, m_need, m_step, m_err, m_sticky, m_errcnt, m_wrap;

  gray_checker #(.WRAP_W(8), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .code(code), .en(en), .clr(clr),
    .bin(bin), .valid(valid), .step_ok(step_ok), .err(err),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_bin(input logic [2:0] g);
    for (int i = 0; i < 8; i++)
      if (3'(i ^ (i >> 1)) == g) return i;
    return -1;
  endfunction

  function automatic logic [2:0] to_gray(input int b);
    return 3'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_bin = 0; m_need = 0; m_step = 0; m_err = 0;
    m_sticky = 0; m_errcnt = 0; m_wrap = 0;
  endtask

  task automatic model_step(input logic [2:0] c, input bit e, input bit cl);
    int nb;
    m_step = 0; m_err = 0;
    if (e) begin
      nb = to_bin(c);
      if (!m_valid) begin
        m_valid = 1;
      end else if (nb == (m_bin + 1) % 8) begin
        m_step = 1;
        if (m_bin == 7) m_wrap = (m_wrap + 1) % 256;
        if (m_need > 0) m_need--;
      end else begin
        m_err = 1;
        m_sticky = 1;
        if (m_errcnt < 15) m_errcnt++;
        m_need = 2;
      end
      m_bin = nb;
    end
    if (cl) begin
      m_errcnt = 0; m_wrap = 0; m_sticky = 0;
    end
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, ".bin"}, int'(bin), m_bin);
    chk({ctx, ".valid"}, int'(valid), int'(m_valid));
    chk({ctx, ".step_ok"}, int'(step_ok), m_step);
    chk({ctx, ".err"}, int'(err), m_err);
    chk({ctx, ".err_sticky"}, int'(err_sticky), m_sticky);
    chk({ctx, ".err_cnt"}, int'(err_cnt), m_errcnt);
    chk({ctx, ".wrap_cnt"}, int'(wrap_cnt), m_wrap);
  endtask

  task automatic step(input string ctx, input logic [2:0] c, input bit e, input bit cl);
    @(negedge clk);
    code = c; en = e; clr = cl;
    @(posedge clk);
    #1;
    model_step(c, e, cl);
    compare_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all(ctx);
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0] seq_clean [9];
    model_reset();

    // reset held with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      code = 3'($urandom_range(0, 7)); en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      compare_all("hold_rst");
    end
    @(negedge clk); en = 1'b0; reset = 1'b1;
    step("first", 3'b011, 1, 0);
    chk("first.bin_is_2", int'(bin), 2);

    // clean full lap
    do_reset("rst_clean");
    seq_clean = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    foreach (seq_clean[i]) step("clean", seq_clean[i], 1, 0);
    chk("clean.wrap_is_1", int'(wrap_cnt), 1);

    // illegal jump then two legal steps back into tracking
    do_reset("rst_illegal");
    step("ill", 3'b000, 1, 0);
    step("ill", 3'b001, 1, 0);
    step("ill", 3'b011, 1, 0);
    step("ill", 3'b110, 1, 0);
    chk("ill.err_pulse", int'(err), 1);
    step("resync", 3'b111, 1, 0);
    step("resync", 3'b101, 1, 0);
    step("track", 3'b101, 1, 0);

    // stalls saturate the error counter
    do_reset("rst_stall");
    step("stall", 3'b000, 1, 0);
    step("stall", 3'b001, 1, 0);
    for (int i = 0; i < 20; i++) step("stall", 3'b001, 1, 0);
    chk("stall.err_cnt_sat", int'(err_cnt), 15);
    for (int b = 2; b < 6; b++) begin
      for (int g = 0; g < 5; g++) step("gap", 3'($urandom_range(0, 7)), 0, 0);
      step("resume", to_gray(b), 1, 0);
    end

    // clear colliding with an error and with a wrap
    do_reset("rst_clr");
    step("clr", 3'b000, 1, 0);
    step("clr", 3'b001, 1, 0);
    step("clr_err", 3'b000, 1, 1);
    chk("clr_err.err_cnt", int'(err_cnt), 0);
    for (int b = 1; b < 8; b++) step("clr", to_gray(b), 1, 0);
    step("clr_wrap", 3'b000, 1, 1);
    chk("clr_wrap.wrap_cnt", int'(wrap_cnt), 0);

    // reset in the middle of a run
    do_reset("rst_mid0");
    for (int b = 0; b < 6; b++) step("mid", to_gray(b), 1, 0);
    do_reset("rst_mid");
    step("after_rst", 3'b010, 1, 0);
    chk("after_rst.bin_is_3", int'(bin), 3);

    // mostly-legal random traffic with occasional faults, clears and resets
    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [2:0] c;
      r = $urandom_range(0, 99);
      if (r < 70) c = to_gray((m_bin + 1) % 8);
      else        c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
      step("rand", c, $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
